// File: rtl/seq_window_ctrl.sv
// Run-time configurable serial pattern detector running one bounded job per start.
// Latches pattern/len/overlap/window, samples qualified bits, counts Mealy matches, pulses done.
module seq_window_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [4:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             x_valid,
  input  logic             x,
  output logic             busy,
  output logic             z,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] MAX_LEN = 5'(PAT_W);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat;
  logic [4:0]       len;
  logic             overlap;
  logic [CNT_W-1:0] window;
  logic [PAT_W-2:0] hist;
  logic [4:0]       fill;
  logic [CNT_W-1:0] sample_cnt;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic             cfg_ok;
  logic             sample;
  logic             last;
  logic             fill_ok;
  logic             hit;
  logic             accept;

  // Match evaluation on the candidate window ending with the current bit
  always_comb begin
    len_mask = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (6'(i) < {1'b0, len});
    end
    cand    = {hist, x};
    fill_ok = ({1'b0, fill} + 6'd1) >= {1'b0, len};
    hit     = (((cand ^ pat) & len_mask) == {PAT_W{1'b0}}) && fill_ok;
    cfg_ok  = (cfg_len != 5'd0) && (cfg_len <= MAX_LEN) && (cfg_window != {CNT_W{1'b0}});
    sample  = (state == RUN) && x_valid;
    last    = (sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) == window;
    accept  = (state == IDLE) && start && cfg_ok;
  end

  // Next-state logic; abort takes priority over the final sample
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        if (abort)              state_nxt = IDLE;
        else if (sample && last) state_nxt = DONE;
        else                    state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign z    = sample && hit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Config latches, history, counters and the registered reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat         <= {PAT_W{1'b0}};
      len         <= 5'd0;
      overlap     <= 1'b0;
      window      <= {CNT_W{1'b0}};
      hist        <= {(PAT_W-1){1'b0}};
      fill        <= 5'd0;
      sample_cnt  <= {CNT_W{1'b0}};
      match_count <= {CNT_W{1'b0}};
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (accept) begin
        pat         <= cfg_pattern;
        len         <= cfg_len;
        overlap     <= cfg_overlap;
        window      <= cfg_window;
        hist        <= {(PAT_W-1){1'b0}};
        fill        <= 5'd0;
        sample_cnt  <= {CNT_W{1'b0}};
        match_count <= {CNT_W{1'b0}};
      end else if (sample) begin
        hist        <= cand[PAT_W-2:0];
        sample_cnt  <= sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        match_count <= match_count + {{(CNT_W-1){1'b0}}, hit};
        // Non-overlap restarts the fill so the next hit needs a full fresh pattern
        if (hit && !overlap)   fill <= 5'd0;
        else if (fill < MAX_LEN) fill <= fill + 5'd1;
        else                   fill <= fill;
      end else begin
        hist <= hist;
      end
    end
  end

endmodule

// File: tb/tb_seq_window_ctrl.sv
// Directed self-checking bench for seq_window_ctrl with hand-computed expectations.
module tb_seq_window_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] cfg_pattern;
  logic [4:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_window;
  logic       x_valid, x;
  logic       busy, z, done, cfg_err;
  logic [7:0] match_count;

  int tests = 0;
  int fails = 0;

  seq_window_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window), .x_valid(x_valid), .x(x),
    .busy(busy), .z(z), .done(done), .cfg_err(cfg_err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample i (1-based) is bits[i-1]; z expected on sample i when zexp[i-1]
  task automatic run_job(input string tag, input logic [7:0] pat, input logic [4:0] len,
                         input logic ovl, input logic [7:0] win, input logic [15:0] bits,
                         input logic [15:0] zexp, input bit gaps, input int abort_after,
                         input logic [7:0] exp_cnt);
    start = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_window = win;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy_start"}, busy, 1);
    for (int i = 0; i < int'(win); i++) begin
      if (gaps && i > 0) begin
        x_valid = 1'b0; x = ~x; start = 1'b1; cfg_len = 5'd0;
        #1 check_eq({tag, "_gap_z"}, z, 0);
        tick();
        start = 1'b0;
        check_eq({tag, "_gap_busy"}, busy, 1);
        check_eq({tag, "_gap_cfg_err"}, cfg_err, 0);
      end
      x_valid = 1'b1; x = bits[i];
      #1 check_eq($sformatf("%s_z%0d", tag, i + 1), z, zexp[i]);
      tick();
      x_valid = 1'b0;
      if (abort_after == i + 1) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq({tag, "_abort_busy"}, busy, 0);
        check_eq({tag, "_abort_done"}, done, 0);
        check_eq({tag, "_abort_cnt"}, match_count, exp_cnt);
        tick();
        check_eq({tag, "_abort_no_done"}, done, 0);
        return;
      end
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_cnt"}, match_count, exp_cnt);
    // start in DONE with an illegal window must be ignored entirely
    start = 1'b1; cfg_window = 8'd0;
    tick();
    start = 1'b0;
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_done_start_ign"}, cfg_err, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic cfg_bad(input string tag, input logic [4:0] len, input logic [7:0] win,
                         input logic [7:0] prev_cnt);
    start = 1'b1; cfg_pattern = 8'h05; cfg_len = len; cfg_overlap = 1'b1; cfg_window = win;
    tick();
    start = 1'b0;
    check_eq({tag, "_err"}, cfg_err, 1);
    check_eq({tag, "_busy"}, busy, 0);
    tick();
    check_eq({tag, "_err_clr"}, cfg_err, 0);
    check_eq({tag, "_busy2"}, busy, 0);
    check_eq({tag, "_cnt_hold"}, match_count, prev_cnt);
  endtask

  localparam logic [15:0] STREAM = 16'h00B5;  // 1,0,1,0,1,1,0,1 in sample order
  localparam logic [15:0] Z_OVL  = 16'h0094;  // hits on samples 3,5,8
  localparam logic [15:0] Z_NOVL = 16'h0084;  // hits on samples 3,8

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_pattern = 8'h00; cfg_len = 5'd0;
    cfg_overlap = 1'b0; cfg_window = 8'd0; x_valid = 1'b0; x = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_z", z, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_cnt", match_count, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_job("ovl", 8'h05, 5'd3, 1'b1, 8'd8, STREAM, Z_OVL, 1'b0, 0, 8'd3);
    run_job("novl", 8'h05, 5'd3, 1'b0, 8'd8, STREAM, Z_NOVL, 1'b0, 0, 8'd2);
    run_job("gaps", 8'h05, 5'd3, 1'b1, 8'd8, STREAM, Z_OVL, 1'b1, 0, 8'd3);

    cfg_bad("len0", 5'd0, 8'd8, 8'd3);
    cfg_bad("len9", 5'd9, 8'd8, 8'd3);
    cfg_bad("win0", 5'd3, 8'd0, 8'd3);

    run_job("abort", 8'h05, 5'd3, 1'b1, 8'd8, STREAM, Z_OVL, 1'b0, 5, 8'd2);
    run_job("after_abort", 8'h05, 5'd3, 1'b1, 8'd8, STREAM, Z_OVL, 1'b0, 0, 8'd3);

    run_job("win1", 8'h01, 5'd1, 1'b1, 8'd1, 16'h0001, 16'h0001, 1'b0, 0, 8'd1);
    // Full-length pattern 1011_0101 sent once: hits only on the 8th bit
    run_job("len8", 8'hB5, 5'd8, 1'b1, 8'd8, 16'h00AD, 16'h0080, 1'b0, 0, 8'd1);

    // Reset asserted between edges while a hit is being presented
    start = 1'b1; cfg_pattern = 8'h05; cfg_len = 5'd3; cfg_overlap = 1'b1; cfg_window = 8'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1; x = STREAM[i];
      tick();
    end
    x_valid = 1'b1; x = 1'b1;
    #1 check_eq("rstmid_z_pre", z, 1);
    check_eq("rstmid_cnt_pre", match_count, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_z", z, 0);
    check_eq("rstmid_done", done, 0);
    check_eq("rstmid_cnt", match_count, 0);
    x_valid = 1'b0;
    tick();
    check_eq("rstmid_no_done", done, 0);
    rst = 1'b0;
    tick();
    run_job("post_rst", 8'h05, 5'd3, 1'b1, 8'd8, STREAM, Z_OVL, 1'b0, 0, 8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_window_ctrl.md
# seq_window_ctrl

Programmable serial pattern detector controller that runs one bounded detection job per start command. It latches a pattern, pattern length, overlap mode and window size, then samples a qualified serial bit stream for exactly that many valid bits. It raises a Mealy match strobe on each hit, counts hits, and signals completion with a one-cycle done pulse. It sits between a configuring master and the serial input, replacing fixed-pattern Mealy detectors with a single run-time configurable, start/done sequenced unit.

## Interface
- PAT_W, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, width of the window size and of the match counter
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high; returns the block to IDLE
- start  in  1  job request; sampled only in IDLE
- abort  in  1  cancels a running job; sampled only in RUN
- cfg_pattern  in  PAT_W  pattern, right-aligned; bit [cfg_len-1] is the first bit expected
- cfg_len  in  5  pattern length; legal range 1..PAT_W
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_window  in  CNT_W  number of valid bits to sample; legal range ≥1
- x_valid  in  1  qualifies x this cycle
- x  in  1  serial data bit
- busy  out  1  high while in RUN
- z  out  1  combinational Mealy match strobe
- done  out  1  one-cycle job-complete pulse
- cfg_err  out  1  one-cycle pulse when start is rejected
- match_count  out  CNT_W  number of matches in the current or last job

## Operation
- States: IDLE, RUN, DONE. State register, config latches and counters are reset by rst.
- IDLE:
  - If start=1 and the config is legal (1 ≤ cfg_len ≤ PAT_W and cfg_window ≠ 0):
    - latch pattern, len, overlap and window;
    - clear the history shift register, fill counter, sample counter and match_count;
    - go to RUN.
  - If start=1 and the config is illegal: pulse cfg_err for one cycle, stay in IDLE, leave match_count unchanged.
- RUN, on each cycle with x_valid=1:
  - Form cand = {hist[PAT_W-2:0], x}.
  - A match occurs when cand[len-1:0] == pattern[len-1:0] and fill+1 ≥ len.
  - z = RUN & x_valid & match, combinational in the same cycle.
  - On the clock edge: hist ← cand; sample_cnt += 1; match_count += match.
  - fill ← 0 if (match & ~overlap); otherwise fill ← min(fill+1, PAT_W).
  - If sample_cnt+1 == window, go to DONE (the final bit is still evaluated and counted).
- RUN with x_valid=0: no state change, and z=0.
- abort=1 in RUN: go to IDLE next edge. No done pulse. match_count holds the partial value. The abort cycle's bit is still evaluated if x_valid=1, and z and match_count reflect it.
- abort and the final sample in the same cycle: abort wins and no done pulse is issued.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- start is ignored in RUN and DONE. Config inputs are don't-care outside the accepted start cycle.
- match_count never exceeds window, so no saturation is needed. It holds its value until the next accepted start.

## Timing
- Reset values: busy=0, z=0, done=0, cfg_err=0, match_count=0, state=IDLE. Reset mid-job discards the job with no done pulse.
- start accepted at edge N: busy=1 from cycle N+1, and the first sample can be taken in cycle N+1.
- z has zero latency: it is asserted during the cycle that presents the completing bit. match_count reflects the hit after the following edge.
- When the final sample is presented in cycle M: busy drops and done=1 in cycle M+1, and match_count is final in M+1. IDLE is reached in M+2, so start can next be accepted in cycle M+2.
- cfg_err is registered: it is high in the cycle after the rejected start.

## Test plan
- Overlap, pattern 101 (cfg_pattern=0x05, len=3, window=8), stream 1,0,1,0,1,1,0,1 → z on samples 3, 5 and 8; done one cycle after sample 8; match_count=3.
- Non-overlap, same stream and config with cfg_overlap=0 → z on samples 3 and 8 only; match_count=2.
- x_valid gaps: the overlap stream with x_valid=0 inserted between every bit, and x toggling during the gaps → identical z sample positions; match_count=3; gap cycles show z=0.
- Config errors: start with cfg_len=0, then with cfg_len=PAT_W+1, then with cfg_window=0 → cfg_err pulse each time, busy stays 0, match_count keeps its prior value; start during RUN is ignored.
- Abort: abort asserted after sample 5 of the overlap stream → busy=0 next cycle, no done pulse, match_count=2; a fresh start then runs normally.
- Reset mid-RUN: rst asserted asynchronously between clock edges → all outputs 0 immediately, and the state is IDLE; the next start behaves identically to a post-power-up start.
